// File: rtl/lz4_hash_window_gen_pkg.sv
// Shared constants, FSM state encoding and the multiplicative hash used by the LZ4 hash window generator.
package lz4_hash_window_gen_pkg;

    localparam int          LZ4_MFLIMIT    = 12;
    localparam int          LZ4_HASH_BITS  = 12;
    localparam logic [31:0] LZ4_HASH_PRIME = 32'h9E3779B1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } lz4_state_e;

    // Full 32-bit product; callers keep the top HASH_BITS bits.
    function automatic logic [31:0] lz4_mult(input logic [31:0] win);
        return win * LZ4_HASH_PRIME;
    endfunction

endpackage

// File: rtl/lz4_hash_window_gen_obuf.sv
// Output beat buffer: synchronous FIFO with registered storage and an occupancy count.
module lz4_hash_window_gen_obuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/lz4_hash_window_gen.sv
// Pulls 4 overlapping 32-bit windows per beat from the byte-addressing unit, hashes each lane and
// hands position/mask/hash/data beats to the match stage, stopping at the last legal match start.
//
//   state    | meaning
//   IDLE     | waiting for a rising edge on start
//   INIT     | addressing unit enabled, waiting for it to leave busy
//   RUN      | issuing one beat request per cycle while credits allow
//   DRAIN    | all requests issued, waiting for the pipeline and buffer to empty
//   DONE     | one-cycle done pulse, then back to IDLE
module lz4_hash_window_gen
    import lz4_hash_window_gen_pkg::*;
#(
    parameter int HASH_BITS  = LZ4_HASH_BITS,
    parameter int POS_W      = 16,
    parameter int OBUF_DEPTH = 4,
    parameter int MFLIMIT    = LZ4_MFLIMIT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [POS_W-1:0]       blk_len_i,
    output logic                   done_o,
    output logic                   byte4_en_o,
    input  logic                   byte4_busy_i,
    output logic                   rd_data_en_o,
    output logic                   shift_en_o,
    output logic [2:0]             shift_dist_o,
    input  logic                   byte4_valid_i,
    input  logic [31:0]            byte4_data1_i,
    input  logic [31:0]            byte4_data2_i,
    input  logic [31:0]            byte4_data3_i,
    input  logic [31:0]            byte4_data4_i,
    output logic                   hv_valid_o,
    input  logic                   hv_ready_i,
    output logic [POS_W-1:0]       hv_pos_o,
    output logic [3:0]             hv_mask_o,
    output logic [4*HASH_BITS-1:0] hv_hash_o,
    output logic [127:0]           hv_data_o
);

    localparam int CW      = $clog2(OBUF_DEPTH) + 1;
    localparam int ENTRY_W = POS_W + 4 + 4*HASH_BITS + 128;

    lz4_state_e         state_q;
    logic               start_q;
    logic               byte4_en_q;
    logic               done_q;
    logic [POS_W-1:0]   limit_q;
    logic [POS_W-1:0]   req_pos_q;
    logic [CW-1:0]      credits_q;
    logic               inflight_q;
    logic [POS_W-1:0]   inflight_pos_q;
    logic               cap_valid_q;
    logic [POS_W-1:0]   cap_pos_q;
    logic [127:0]       cap_data_q;
    logic               err_q;

    logic               rd_req;
    logic               pop;
    logic [3:0]         mask_w;
    logic [4*HASH_BITS-1:0] hash_w;
    logic [ENTRY_W-1:0] entry_w;
    logic [ENTRY_W-1:0] head_w;
    logic [CW-1:0]      count_w;

    assign rd_req = (state_q == ST_RUN) && (req_pos_q <= limit_q)
                    && (credits_q != '0) && !byte4_busy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            byte4_en_q <= 1'b0;
            done_q     <= 1'b0;
            limit_q    <= '0;
            req_pos_q  <= '0;
        end else begin
            start_q <= start_i;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !start_q) begin
                        req_pos_q <= '0;
                        limit_q   <= blk_len_i - POS_W'(MFLIMIT);
                        if (blk_len_i <= POS_W'(MFLIMIT)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_INIT;
                            byte4_en_q <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    if (!byte4_busy_i) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_req) begin
                        req_pos_q <= req_pos_q + POS_W'(4);
                        if ((req_pos_q + POS_W'(4)) > limit_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_q && !cap_valid_q && (count_w == '0)) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        byte4_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    byte4_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Every request reserves a buffer slot up front, so a returning beat can always be accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q      <= CW'(OBUF_DEPTH);
            inflight_q     <= 1'b0;
            inflight_pos_q <= '0;
            cap_valid_q    <= 1'b0;
            cap_pos_q      <= '0;
            cap_data_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            credits_q   <= credits_q - CW'(rd_req) + CW'(pop);
            inflight_q  <= rd_req;
            if (rd_req) begin
                inflight_pos_q <= req_pos_q;
            end
            cap_valid_q <= byte4_valid_i && inflight_q;
            if (byte4_valid_i && inflight_q) begin
                cap_pos_q  <= inflight_pos_q;
                cap_data_q <= {byte4_data4_i, byte4_data3_i, byte4_data2_i, byte4_data1_i};
            end
            err_q <= err_q | (byte4_valid_i & ~inflight_q);
        end
    end

    always_comb begin
        mask_w = '0;
        hash_w = '0;
        for (int i = 0; i < 4; i++) begin
            mask_w[i] = (cap_pos_q + POS_W'(i)) <= limit_q;
            hash_w[i*HASH_BITS +: HASH_BITS] =
                HASH_BITS'(lz4_mult(cap_data_q[i*32 +: 32]) >> (32 - HASH_BITS));
        end
    end

    assign entry_w = {cap_pos_q, mask_w, hash_w, cap_data_q};

    lz4_hash_window_gen_obuf #(
        .DEPTH (OBUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cap_valid_q),
        .wdata_i (entry_w),
        .pop_i   (pop),
        .rdata_o (head_w),
        .count_o (count_w)
    );

    assign hv_valid_o = (count_w != '0);
    assign pop        = hv_valid_o && hv_ready_i;
    assign {hv_pos_o, hv_mask_o, hv_hash_o, hv_data_o} = head_w;

    assign done_o       = done_q;
    assign byte4_en_o   = byte4_en_q;
    assign rd_data_en_o = rd_req;
    assign shift_en_o   = inflight_q;
    assign shift_dist_o = {inflight_q, 2'b00};

endmodule
